sobol_stream: RTL and testbench

SOBOL_STREAM -- requirements
Module: sobol_stream

---
 rtl/sobol_pkg.sv | 36 +++
 rtl/sobol_dir_ram.sv | 39 +++
 rtl/sobol_stream.sv | 213 +++++++++++++++++++++
 tb/tb_sobol_stream.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobol_pkg.sv
// -----------------------------------------------------------------------------
// sobol_pkg
// Shared definitions for the Sobol low-discrepancy stream generator:
//   - WORD_W  : width of direction numbers, Sobol values and path indices
//   - state_t : run-control FSM states (IDLE, RUN, FIN)
//   - ctz()   : count of trailing zeros of a 32-bit word
// -----------------------------------------------------------------------------
package sobol_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Index of the lowest set bit. A zero argument returns 0; the stream
    // only ever asks for ctz(N+1) with N+1 non-zero.
    function automatic logic [4:0] ctz(input logic [WORD_W-1:0] v);
        logic [4:0] r;
        logic       found;
        r     = 5'd0;
        found = 1'b0;
        for (int i = 0; i < WORD_W; i++) begin
            if (!found && v[i]) begin
                r     = 5'(i);
                found = 1'b1;
            end else begin
                r     = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sobol_dir_ram.sv
// -----------------------------------------------------------------------------
// sobol_dir_ram
// Direction-number storage: DEPTH words of WORD_W bits, synchronous write,
// combinational read. Deliberately has no reset so a loaded table survives
// rst_n.
// Ports:
//   clk    in   clock for the write port
//   we     in   write strobe
//   waddr  in   write address (dim*32 + j)
//   wdata  in   direction number to store
//   raddr  in   read address
//   rdata  out  word at raddr (combinational)
// -----------------------------------------------------------------------------
module sobol_dir_ram
    import sobol_pkg::*;
#(
    parameter int DEPTH = 1600,
    parameter int AW    = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_r [DEPTH];

    // Table write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sobol_stream.sv
// -----------------------------------------------------------------------------
// sobol_stream
// Streams Sobol values for path indices 0..n_paths-1, M dimensions per index,
// dimension-major within an index. Each x[d] is maintained incrementally in
// Gray-code order: after the beat (N, d) is accepted, x[d] ^= dir[d][ctz(N+1)].
//
// Build option: define SOBOL_SCRAMBLE_EN to add the scramble_seed input; the
// seed is captured on an accepted start and XORed onto every output value.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start, n_paths  run request and path count (sampled when idle)
//   scramble_seed   digital-shift seed (only with SOBOL_SCRAMBLE_EN)
//   dir_we/waddr/wdata  direction-table write port (ignored while busy)
//   out_valid/out_ready handshake; out_data/out_dim/out_idx/out_last beat
//   busy            run in progress (RUN or FIN)
//   done            one-cycle pulse at run end
// Requires M >= 2.
// -----------------------------------------------------------------------------
module sobol_stream
    import sobol_pkg::*;
#(
    parameter int M  = 50,
    parameter int AW = $clog2(M*32)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WORD_W-1:0]     n_paths,
`ifdef SOBOL_SCRAMBLE_EN
    input  logic [WORD_W-1:0]     scramble_seed,
`endif
    input  logic                  dir_we,
    input  logic [AW-1:0]         dir_waddr,
    input  logic [WORD_W-1:0]     dir_wdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_W-1:0]     out_data,
    output logic [$clog2(M)-1:0]  out_dim,
    output logic [WORD_W-1:0]     out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int            DW       = $clog2(M);
    localparam logic [DW-1:0] LAST_DIM = DW'(M - 1);
    localparam logic [DW-1:0] DIM_ONE  = DW'(1);

    state_t              state_r;
    state_t              state_s;
    logic                out_valid_r;
    logic                busy_r;
    logic                done_r;

    logic [WORD_W-1:0]   x_r [M];
    logic [WORD_W-1:0]   idx_r;
    logic [DW-1:0]       dim_r;
    logic [WORD_W-1:0]   n_paths_r;
    logic [WORD_W-1:0]   out_data_r;
    logic                out_last_r;

    logic                start_acc_s;
    logic                dir_we_s;
    logic                fire_s;
    logic [4:0]          ctz_s;
    logic [AW-1:0]       rd_addr_s;
    logic [WORD_W-1:0]   dir_rdata_s;
    logic [WORD_W-1:0]   x_upd_s;
    logic [DW-1:0]       nxt_dim_s;
    logic [WORD_W-1:0]   nxt_idx_s;
    logic                nxt_last_s;
    logic [WORD_W-1:0]   seed_s;
    logic [WORD_W-1:0]   start_seed_s;

    // Requests are only honoured in IDLE; anything arriving while busy is dropped.
    assign start_acc_s = (state_r == ST_IDLE) && start;
    assign dir_we_s    = (state_r == ST_IDLE) && dir_we;
    assign fire_s      = out_valid_r && out_ready;

    sobol_dir_ram #(
        .DEPTH (M*WORD_W),
        .AW    (AW)
    ) u_dir_ram (
        .clk   (clk),
        .we    (dir_we_s),
        .waddr (dir_waddr),
        .wdata (dir_wdata),
        .raddr (rd_addr_s),
        .rdata (dir_rdata_s)
    );

`ifdef SOBOL_SCRAMBLE_EN
    logic [WORD_W-1:0] seed_r;

    // Capture the digital-shift seed with each accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_r <= '0;
        end else if (start_acc_s) begin
            seed_r <= scramble_seed;
        end
    end

    assign seed_s       = seed_r;
    assign start_seed_s = scramble_seed;
`else
    assign seed_s       = '0;
    assign start_seed_s = '0;
`endif

    // Run-control state register plus registered status outputs decoded from
    // the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            out_valid_r <= (state_s == ST_RUN);
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= (state_s == ST_FIN);
        end
    end

    // Next-state logic: a zero-length run goes straight to FIN.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (n_paths == 32'd0) begin
                        state_s = ST_FIN;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (fire_s && out_last_r) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Beat sequencing: the direction word for the current beat's update is
    // dir[dim][ctz(idx+1)], and the next beat's value comes from x[next dim],
    // which was already brought up to date when that dimension last fired.
    always_comb begin
        ctz_s     = ctz(idx_r + 32'd1);
        rd_addr_s = AW'({dim_r, ctz_s});
        x_upd_s   = x_r[dim_r] ^ dir_rdata_s;
        if (dim_r == LAST_DIM) begin
            nxt_dim_s = '0;
            nxt_idx_s = idx_r + 32'd1;
        end else begin
            nxt_dim_s = dim_r + DIM_ONE;
            nxt_idx_s = idx_r;
        end
        nxt_last_s = (nxt_dim_s == LAST_DIM) && (nxt_idx_s == n_paths_r - 32'd1);
    end

    // Datapath: Sobol state, counters and the registered output beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < M; i++) begin
                x_r[i] <= '0;
            end
            idx_r      <= '0;
            dim_r      <= '0;
            n_paths_r  <= '0;
            out_data_r <= '0;
            out_last_r <= 1'b0;
        end else if (start_acc_s) begin
            for (int i = 0; i < M; i++) begin
                x_r[i] <= '0;
            end
            idx_r      <= '0;
            dim_r      <= '0;
            n_paths_r  <= n_paths;
            out_data_r <= start_seed_s;
            out_last_r <= 1'b0;
        end else if (fire_s) begin
            x_r[dim_r] <= x_upd_s;
            if (!out_last_r) begin
                idx_r      <= nxt_idx_s;
                dim_r      <= nxt_dim_s;
                out_data_r <= x_r[nxt_dim_s] ^ seed_s;
                out_last_r <= nxt_last_s;
            end else begin
                out_last_r <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_dim   = dim_r;
    assign out_idx   = idx_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_sobol_stream.sv
// -----------------------------------------------------------------------------
// tb_sobol_stream
// Drives sobol_stream with directed and randomized stimulus. A reference model
// observes the inputs each cycle, tracks the run phase, path index and
// dimension, and computes every expected value in closed form:
// XOR of dir[d*32+j] over the set bits j of gray(N) = N ^ (N>>1).
// -----------------------------------------------------------------------------
module tb_sobol_stream;

    localparam int M  = 2;
    localparam int AW = $clog2(M*32);
    localparam int DW = $clog2(M);

    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_FIN  = 2;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic [31:0]   n_paths   = 32'd0;
    logic          dir_we    = 1'b0;
    logic [AW-1:0] dir_waddr = '0;
    logic [31:0]   dir_wdata = 32'd0;
    logic          out_ready = 1'b0;
`ifdef SOBOL_SCRAMBLE_EN
    logic [31:0]   scramble_seed = 32'd0;
`endif
    logic          out_valid;
    logic [31:0]   out_data;
    logic [DW-1:0] out_dim;
    logic [31:0]   out_idx;
    logic          out_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    sobol_stream #(.M(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_paths   (n_paths),
`ifdef SOBOL_SCRAMBLE_EN
        .scramble_seed (scramble_seed),
`endif
        .dir_we    (dir_we),
        .dir_waddr (dir_waddr),
        .dir_wdata (dir_wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_dim   (out_dim),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    int          n_vec  = 0;
    int          n_err  = 0;
    int          scen   = 0;
    int          to_req = 0;
    logic [31:0] m_dir [M*32];

    function automatic logic [31:0] sobol_ref(input logic [31:0] n, input int d);
        logic [31:0] g;
        logic [31:0] r;
        g = n ^ (n >> 1);
        r = 32'd0;
        for (int j = 0; j < 32; j++) begin
            if (g[j]) r = r ^ m_dir[d*32 + j];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model and compare process, evaluated mid-cycle.
    initial begin : compare
        int          m_phase;
        int          m_dim;
        int          to_seen;
        logic [31:0] m_idx, m_n, m_seed, m_beats, exp_d, lit;
        logic        hold_v, hold_last;
        logic [31:0] hold_data, hold_idx;
        logic [DW-1:0] hold_dim;
        m_phase = P_IDLE; m_dim = 0; to_seen = 0;
        m_idx = 32'd0; m_n = 32'd0; m_seed = 32'd0; m_beats = 32'd0;
        hold_v = 1'b0; hold_last = 1'b0; hold_data = 32'd0; hold_idx = 32'd0; hold_dim = '0;
        for (int i = 0; i < M*32; i++) m_dir[i] = 32'd0;
        forever begin
            @(negedge clk);
            if (to_req != to_seen) begin
                n_vec++;
                n_err++;
                $display("FAIL timeout: expired waits %0d, want 0", to_req - to_seen);
                to_seen = to_req;
            end
            if (!rst_n) begin
                m_phase = P_IDLE; m_idx = 32'd0; m_dim = 0; hold_v = 1'b0;
                chk("rst_valid", 32'(out_valid), 32'd0);
                chk("rst_data",  out_data,       32'd0);
                chk("rst_dim",   32'(out_dim),   32'd0);
                chk("rst_idx",   out_idx,        32'd0);
                chk("rst_last",  32'(out_last),  32'd0);
                chk("rst_busy",  32'(busy),      32'd0);
                chk("rst_done",  32'(done),      32'd0);
            end else begin
                chk("busy",  32'(busy),      32'(m_phase != P_IDLE));
                chk("done",  32'(done),      32'(m_phase == P_FIN));
                chk("valid", 32'(out_valid), 32'(m_phase == P_RUN));
                if (m_phase == P_RUN) begin
                    exp_d = sobol_ref(m_idx, m_dim) ^ m_seed;
                    chk("data", out_data,       exp_d);
                    chk("dim",  32'(out_dim),   32'(m_dim));
                    chk("idx",  out_idx,        m_idx);
                    chk("last", 32'(out_last),  32'((m_idx == m_n - 32'd1) && (m_dim == M-1)));
                    if (hold_v) begin
                        chk("hold_data", out_data,      hold_data);
                        chk("hold_dim",  32'(out_dim),  32'(hold_dim));
                        chk("hold_idx",  out_idx,       hold_idx);
                        chk("hold_last", 32'(out_last), 32'(hold_last));
                    end
                    if (scen == 1) begin
                        chk("req038_last", 32'(out_last), 32'(m_beats == 32'd7));
                        if (m_dim == 0) begin
                            case (m_idx)
                                32'd0:   lit = 32'h0000_0000;
                                32'd1:   lit = 32'h8000_0000;
                                32'd2:   lit = 32'hC000_0000;
                                default: lit = 32'h4000_0000;
                            endcase
                            chk("req038_dim0", out_data, lit);
                            chk("model_pin", sobol_ref(m_idx, 0), lit);
                        end
                    end
                    if (scen == 3 && m_idx == 32'd0) begin
                        chk("req043_seed", out_data, 32'hDEAD_BEEF);
                    end
                end
                hold_v    = out_valid && !out_ready;
                hold_data = out_data;
                hold_dim  = out_dim;
                hold_idx  = out_idx;
                hold_last = out_last;
                // Advance the model to what the coming clock edge must produce.
                case (m_phase)
                    P_IDLE: begin
                        if (dir_we) m_dir[dir_waddr] = dir_wdata;
                        if (start) begin
                            m_idx = 32'd0; m_dim = 0; m_n = n_paths; m_beats = 32'd0;
`ifdef SOBOL_SCRAMBLE_EN
                            m_seed = scramble_seed;
`else
                            m_seed = 32'd0;
`endif
                            m_phase = (n_paths == 32'd0) ? P_FIN : P_RUN;
                        end
                    end
                    P_RUN: begin
                        if (out_ready) begin
                            m_beats++;
                            if (m_idx == m_n - 32'd1 && m_dim == M-1) begin
                                m_phase = P_FIN;
                            end else if (m_dim == M-1) begin
                                m_dim = 0;
                                m_idx++;
                            end else begin
                                m_dim++;
                            end
                        end
                    end
                    default: m_phase = P_IDLE;
                endcase
            end
        end
    end

    task automatic dir_write(input int addr, input logic [31:0] data);
        dir_we = 1'b1; dir_waddr = AW'(addr); dir_wdata = data;
        @(posedge clk); #1;
        dir_we = 1'b0;
    endtask

    task automatic start_run(input logic [31:0] n);
        start = 1'b1; n_paths = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (!done) to_req++;
        @(posedge clk); #1;
    endtask

    // Stimulus.
    initial begin : stim
        int k;
        bit got;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Dim 0: v_j = 1<<(31-j); dim 1 random.
        for (int j = 0; j < 32; j++) dir_write(j, 32'h8000_0000 >> j);
        for (int j = 0; j < 32; j++) dir_write(32 + j, $urandom());

        // Hand-checked 4-path run at full throughput.
        scen = 1; out_ready = 1'b1;
        start_run(32'd4);
        wait_done(100);
        scen = 0;

        // Zero-length run.
        start_run(32'd0);
        wait_done(10);

        // Random table, 1000 paths, random backpressure, requests while busy.
        for (int a = 0; a < M*32; a++) dir_write(a, $urandom());
`ifdef SOBOL_SCRAMBLE_EN
        scramble_seed = $urandom();
`endif
        start_run(32'd1000);
        got = 1'b0;
        for (int c = 0; c < 12000 && !got; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            dir_we    = ($urandom_range(0, 7) == 0);
            dir_waddr = AW'($urandom_range(0, M*32-1));
            dir_wdata = $urandom();
            start     = ($urandom_range(0, 15) == 0);
            n_paths   = $urandom_range(0, 50);
            @(posedge clk); #1;
            if (done) got = 1'b1;
        end
        start = 1'b0; dir_we = 1'b0; out_ready = 1'b1;
        if (!got) to_req++;
        @(posedge clk); #1;

        // Reset in the middle of a run, then restart.
        start_run(32'd20);
        k = 0;
        while (!(out_valid && out_idx == 32'd5) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (!(out_valid && out_idx == 32'd5)) to_req++;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        start_run(32'd3);
        wait_done(50);

`ifdef SOBOL_SCRAMBLE_EN
        scen = 3; scramble_seed = 32'hDEAD_BEEF;
        start_run(32'd1);
        wait_done(20);
        scen = 0;
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
